inst_fetch: RTL and testbench

Instruction fetch stage for the single-cycle RISC-V core: owns the program counter, fetches one 32-bit instruction at a time from instruction memory over a request/grant/response handshake, and presents it as `inst` to the control unit and datapath. It consumes the control unit's `PCSel` and the ALU result to select the next PC when the current instruction retires.

---
 rtl/inst_fetch.sv | 100 ++++++++++
 tb/tb_inst_fetch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches one instruction at a time over a
// req/gnt/rvalid handshake, holds it for the core until retired, then selects the next PC.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSel,
  input  logic [31:0] alu_out,
  input  logic        inst_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  localparam logic [2:0] StReset = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StFault = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] next_pc;

  // Next-PC select; bit 0 of a jump target is always dropped, bit 1 set means misaligned.
  always_comb begin
    next_pc = PCSel ? {alu_out[31:1], 1'b0} : pc_q + 32'd4;
  end

  // Next-state logic for the fetch FSM, PC and held instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      StReset: state_d = StReq;
      StReq: begin
        if (imem_gnt) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (inst_ready) begin
          inst_d = NOP_INST;
          if (next_pc[1]) begin
            // PC keeps the faulting instruction's address for diagnosis.
            state_d = StFault;
          end else begin
            pc_d    = next_pc;
            state_d = StReq;
          end
        end
      end
      StFault: state_d = StFault;
      default: begin
        state_d = StReset;
        inst_d  = NOP_INST;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReset;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Outputs decoded from registered state only, so they are stable across a cycle.
  always_comb begin
    imem_req    = (state_q == StReq);
    imem_addr   = pc_q;
    inst        = inst_q;
    inst_valid  = (state_q == StHold);
    pc          = pc_q;
    pc_plus4    = pc_q + 32'd4;
    fetch_fault = (state_q == StFault);
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: drives the memory handshake by hand and checks
// outputs on the falling edge against hand-computed values.
module tb_inst_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSel = 1'b0;
  logic [31:0] alu_out = 32'h0;
  logic        inst_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  inst_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .PCSel      (PCSel),
    .alu_out    (alu_out),
    .inst_ready (inst_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; inputs set before it are sampled at the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_pc4"}, pc_plus4, 32'h4);
    chk({tag, "_inst"}, inst, Nop);
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
  endtask

  // Expects the DUT in REQ at addr; stalls grant/response and checks the held instruction.
  task automatic fetch(input int gstall, input int rstall, input logic [31:0] data,
                       input logic [31:0] addr, input bit spurious);
    logic [31:0] addr4;
    addr4 = addr + 32'd4;
    for (int i = 0; i < gstall; i++) begin
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, addr);
      imem_gnt    = 1'b0;
      imem_rvalid = spurious;
      imem_rdata  = 32'hDEAD_BEEF;
      step();
    end
    chk("req", {31'b0, imem_req}, 32'd1);
    chk("addr", imem_addr, addr);
    chk("fetch_inst_nop", inst, Nop);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    step();
    imem_gnt = 1'b0;
    chk("wait_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < rstall; i++) begin
      chk("wait_valid", {31'b0, inst_valid}, 32'd0);
      step();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk("hold_valid", {31'b0, inst_valid}, 32'd1);
    chk("hold_inst", inst, data);
    chk("hold_pc", pc, addr);
    chk("hold_pc4", pc_plus4, addr4);
    chk("hold_fault", {31'b0, fetch_fault}, 32'd0);
    // Instruction must stay put while the core has not retired it.
    step();
    chk("hold_stable", inst, data);
    chk("hold_stable_valid", {31'b0, inst_valid}, 32'd1);
  endtask

  task automatic retire(input logic sel, input logic [31:0] tgt);
    inst_ready = 1'b1;
    PCSel      = sel;
    alu_out    = tgt;
    step();
    inst_ready = 1'b0;
    PCSel      = 1'b0;
    alu_out    = 32'h0;
    chk("retire_valid", {31'b0, inst_valid}, 32'd0);
    chk("retire_inst", inst, Nop);
  endtask

  initial begin
    step();
    step();
    chk_reset("rst");
    rst = 1'b0;
    step();
    // First fetch at RESET_PC with zero-wait memory.
    fetch(0, 0, 32'h0050_0093, 32'h0, 1'b0);
    retire(1'b0, 32'h0);
    fetch(0, 0, 32'h0010_0113, 32'h4, 1'b0);
    retire(1'b0, 32'h0);
    fetch(0, 0, 32'h0020_0193, 32'h8, 1'b0);
    retire(1'b0, 32'h0);
    fetch(0, 0, 32'h0030_0213, 32'hC, 1'b0);
    retire(1'b0, 32'h0);
    fetch(0, 0, 32'h0040_0293, 32'h10, 1'b0);
    // Taken branch to odd target: bit 0 dropped, no fault.
    retire(1'b1, 32'h0000_0101);
    chk("br_fault", {31'b0, fetch_fault}, 32'd0);
    fetch(4, 3, 32'h1234_5678, 32'h100, 1'b1);
    // Jump to the top word, then sequential wrap to 0 without fault.
    retire(1'b1, 32'hFFFF_FFFD);
    fetch(0, 1, 32'hCAFE_0013, 32'hFFFF_FFFC, 1'b0);
    retire(1'b0, 32'h0);
    chk("wrap_fault", {31'b0, fetch_fault}, 32'd0);
    fetch(0, 0, 32'h00A0_0513, 32'h0, 1'b0);
    // Misaligned target: sticky fault, PC keeps old value.
    retire(1'b1, 32'h0000_0102);
    for (int i = 0; i < 3; i++) begin
      chk("flt_fault", {31'b0, fetch_fault}, 32'd1);
      chk("flt_pc", pc, 32'h0);
      chk("flt_req", {31'b0, imem_req}, 32'd0);
      chk("flt_valid", {31'b0, inst_valid}, 32'd0);
      chk("flt_inst", inst, Nop);
      inst_ready  = 1'b1;
      imem_rvalid = 1'b1;
      imem_gnt    = 1'b1;
      step();
    end
    inst_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    // Reset clears the fault; then reset again while waiting for a response.
    rst = 1'b1;
    step();
    chk_reset("rst2");
    rst = 1'b0;
    step();
    chk("rq_req", {31'b0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wt_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    step();
    chk_reset("rst3");
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    step();
    chk("stray_inst", inst, Nop);
    chk("stray_req", {31'b0, imem_req}, 32'd1);
    chk("stray_addr", imem_addr, 32'h0);
    step();
    chk("stray_inst2", inst, Nop);
    chk("stray_valid", {31'b0, inst_valid}, 32'd0);
    fetch(0, 2, 32'h0FF0_0F0F, 32'h0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
